// File: rtl/mult_div.sv
// Execute-stage multiply/divide unit: owns HI/LO, does single-cycle MULT/MULTU and MT*,
// and runs a 32-step restoring divider that stalls the front of the pipeline while busy.
module mult_div #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] hilo_rdata,
    output logic        stall_req,
    output logic [1:0]  fsm_state
);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        q_neg;
    logic        r_neg;

    logic        accept;
    logic        is_div;
    logic        is_signed_div;
    logic        div_start;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Handshake: en marks a valid instruction in EX; the pipeline may advance it only when
    // stall_req is low. A stalled instruction stays on en/funct unchanged, so acceptance is
    // restricted to IDLE to keep the held DIV from starting again.
    assign accept        = (state == IDLE) && en && !flush;
    assign is_div        = (funct == F_DIV) || (funct == F_DIVU);
    assign is_signed_div = (funct == F_DIV);
    assign div_start     = accept && is_div && (operand_b != 32'd0);

    assign stall_req = rst && !flush && (div_start || (state == BUSY));
    assign fsm_state = state;

    assign abs_a = (is_signed_div && operand_a[31]) ? (~operand_a + 32'd1) : operand_a;
    assign abs_b = (is_signed_div && operand_b[31]) ? (~operand_b + 32'd1) : operand_b;

    assign prod_s = {{32{operand_a[31]}}, operand_a} * {{32{operand_b[31]}}, operand_b};
    assign prod_u = {32'd0, operand_a} * {32'd0, operand_b};

    // The 33rd bit of the partial remainder exists only transiently in rem_shift; after a
    // successful subtract the remainder is always below the divisor and fits in 32 bits.
    assign rem_shift = {rem, dvd[31]};
    assign rem_ge    = (rem_shift >= {1'b0, dvs});
    assign rem_diff  = rem_shift[31:0] - dvs;

    assign q_fix = q_neg ? (~quot + 32'd1) : quot;
    assign r_fix = r_neg ? (~rem + 32'd1) : rem;

    always_comb begin
        hilo_rdata = 32'd0;
        case (funct)
            F_MFHI:  hilo_rdata = hi;
            F_MFLO:  hilo_rdata = lo;
            default: hilo_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (div_start) state_nxt = BUSY;
                BUSY:    if (cnt == CNT_LAST) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            dvd   <= 32'd0;
            dvs   <= 32'd0;
            quot  <= 32'd0;
            rem   <= 32'd0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (div_start) begin
            cnt   <= '0;
            dvd   <= abs_a;
            dvs   <= abs_b;
            quot  <= 32'd0;
            rem   <= 32'd0;
            q_neg <= is_signed_div && (operand_a[31] ^ operand_b[31]);
            r_neg <= is_signed_div && operand_a[31];
        end else if ((state == BUSY) && !flush) begin
            cnt  <= cnt + CNT_W'(1);
            dvd  <= {dvd[30:0], 1'b0};
            quot <= {quot[30:0], rem_ge};
            rem  <= rem_ge ? rem_diff : rem_shift[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (!flush) begin
            if (state == DONE) begin
                lo <= q_fix;
                hi <= r_fix;
            end else if (accept) begin
                case (funct)
                    F_MULT:  {hi, lo} <= prod_s;
                    F_MULTU: {hi, lo} <= prod_u;
                    F_MTHI:  hi <= operand_a;
                    F_MTLO:  lo <= operand_a;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Bench for mult_div: directed corner cases with literal results, then random instruction
// streams checked every cycle against an arithmetic model of HI/LO and divide latency.
module tb_mult_div;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk;
    logic        rst;
    logic        en;
    logic        flush;
    logic [5:0]  funct;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hilo_rdata;
    logic        stall_req;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    // Model: architectural HI/LO, pending divide result, and cycles elapsed since accept
    // (0 = no divide outstanding; divide writes at the end of cycle 33).
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_q;
    logic [31:0] m_r;
    int          m_k;

    mult_div dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .funct      (funct),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .flush      (flush),
        .hi         (hi),
        .lo         (lo),
        .hilo_rdata (hilo_rdata),
        .stall_req  (stall_req),
        .fsm_state  (fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        longint sa, sb, sq, sr;
        logic [63:0] up;
        if (flush) begin
            m_k = 0;
        end else if (m_k == 33) begin
            m_lo = m_q;
            m_hi = m_r;
            m_k  = 0;
        end else if (m_k >= 1) begin
            m_k++;
        end else if (en) begin
            sa = longint'($signed(operand_a));
            sb = longint'($signed(operand_b));
            case (funct)
                F_MULT: begin
                    sq = sa * sb;
                    up = sq;
                    {m_hi, m_lo} = up;
                end
                F_MULTU: begin
                    up = {32'd0, operand_a} * {32'd0, operand_b};
                    {m_hi, m_lo} = up;
                end
                F_MTHI: m_hi = operand_a;
                F_MTLO: m_lo = operand_a;
                F_DIV, F_DIVU: begin
                    if (operand_b != 32'd0) begin
                        if (funct == F_DIVU) begin
                            sa = longint'({32'd0, operand_a});
                            sb = longint'({32'd0, operand_b});
                        end
                        sq = sa / sb;
                        sr = sa % sb;
                        m_q = sq[31:0];
                        m_r = sr[31:0];
                        m_k = 1;
                    end
                end
                default: ;
            endcase
        end
    endfunction

    always @(negedge clk) begin
        logic        exp_stall;
        logic [31:0] exp_rd;
        if (!rst) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
            m_k  = 0;
        end
        exp_rd = (funct == F_MFHI) ? m_hi : (funct == F_MFLO) ? m_lo : 32'd0;
        if (!rst || flush) exp_stall = 1'b0;
        else if (m_k >= 1 && m_k <= 32) exp_stall = 1'b1;
        else exp_stall = (m_k == 0) && en && (funct == F_DIV || funct == F_DIVU)
                         && (operand_b != 32'd0);
        check("model_hi", hi, m_hi);
        check("model_lo", lo, m_lo);
        check("model_stall", 32'(stall_req), 32'(exp_stall));
        check("model_rdata", hilo_rdata, exp_rd);
        if (rst) model_step();
    end

    function automatic logic [5:0] pick_funct();
        case ($urandom_range(0, 9))
            0:       return F_MULT;
            1:       return F_MULTU;
            2, 3:    return F_DIV;
            4:       return F_DIVU;
            5:       return F_MFHI;
            6:       return F_MTHI;
            7:       return F_MFLO;
            8:       return F_MTLO;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called just after a rising edge; holds the instruction while stalled and returns just
    // after the edge where it leaves EX. Operands are scrambled while held to show they are ignored.
    task automatic run(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at, output int stalls);
        int   cyc;
        logic st;
        logic fl;
        cyc       = 0;
        stalls    = 0;
        en        = 1'b1;
        funct     = f;
        operand_a = a;
        operand_b = b;
        flush     = (flush_at == 0);
        forever begin
            @(negedge clk);
            st = stall_req;
            fl = flush;
            if (st) stalls++;
            @(posedge clk);
            #1;
            if (fl || !st) break;
            cyc++;
            if (cyc > 100) begin
                check("run_timeout", 32'(cyc), 32'd0);
                break;
            end
            flush     = (cyc == flush_at);
            operand_a = $urandom;
            operand_b = $urandom;
        end
        en        = 1'b0;
        flush     = 1'b0;
        funct     = pick_funct();
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    task automatic read_chk(input logic [5:0] f, input string name, input logic [31:0] exp);
        en    = 1'b1;
        funct = f;
        @(negedge clk);
        check(name, hilo_rdata, exp);
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic chk_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stalls;
        rst       = 1'b1;
        en        = 1'b0;
        flush     = 1'b0;
        funct     = 6'd0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        read_chk(F_MFHI, "rst_mfhi", 32'd0);
        read_chk(F_MFLO, "rst_mflo", 32'd0);
        run(F_MTHI, 32'h1234_5678, 32'd0, -1, stalls);
        read_chk(F_MFHI, "mthi_mfhi", 32'h1234_5678);

        run(F_MULT, 32'hFFFF_FFFF, 32'd2, -1, stalls);
        check("mult_stalls", 32'(stalls), 32'd0);
        chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run(F_MULTU, 32'hFFFF_FFFF, 32'd2, -1, stalls);
        check("multu_stalls", 32'(stalls), 32'd0);
        chk_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        run(F_DIV, 32'hFFFF_FFF9, 32'd2, -1, stalls);
        check("div_stalls", 32'(stalls), 32'd33);
        chk_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run(F_DIVU, 32'd100, 32'd7, -1, stalls);
        chk_hilo("divu_100_7", 32'd2, 32'd14);
        run(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, stalls);
        chk_hilo("div_ovf", 32'd0, 32'h8000_0000);
        run(F_DIV, 32'd5, 32'd0, -1, stalls);
        check("div0_stalls", 32'(stalls), 32'd0);
        chk_hilo("div0", 32'd0, 32'h8000_0000);

        // Flush in cycle 10 of a divide, then MULTU straight after.
        run(F_DIV, 32'd1000, 32'd3, 10, stalls);
        check("flush_stalls", 32'(stalls), 32'd10);
        en        = 1'b1;
        funct     = F_MULTU;
        operand_a = 32'd3;
        operand_b = 32'd5;
        @(negedge clk);
        check("flush_keep_hi", hi, 32'd0);
        check("flush_keep_lo", lo, 32'h8000_0000);
        check("multu_after_flush_stall", 32'(stall_req), 32'd0);
        @(posedge clk);
        #1 en = 1'b0;
        chk_hilo("multu_after_flush", 32'd0, 32'd15);

        // Asynchronous reset in cycle 20 of a divide.
        run(F_MTHI, 32'h0BAD_BEEF, 32'd0, -1, stalls);
        run(F_MTLO, 32'hCAFE_F00D, 32'd0, -1, stalls);
        en        = 1'b1;
        funct     = F_DIV;
        operand_a = 32'd77;
        operand_b = 32'd5;
        repeat (20) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_stall", 32'(stall_req), 32'd0);
        en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        run(F_DIVU, 32'd9, 32'd3, -1, stalls);
        chk_hilo("divu_9_3", 32'd0, 32'd3);

        for (int i = 0; i < 300; i++) begin
            int fa;
            fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 34)) : -1;
            run(pick_funct(), pick_op(), pick_op(), fa, stalls);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/mult_div.md
# mult_div

Execute-stage multiply/divide unit. Consumes the 6-bit ALU function code produced in ID for the HI/LO-class SPECIAL instructions: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. It owns the architectural HI/LO registers. It runs a multi-cycle radix-2 divider and requests a pipeline stall while a divide is in flight.

## Interface
Parameters:
- `DIV_CYCLES`, default 32. Number of quotient iterations. Fixed to the data width; not intended for override.

Ports:
- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst`  in  1  Asynchronous, active-low reset.
- `en`  in  1  A valid instruction occupies EX this cycle. Held high and stable across a stall.
- `funct`  in  6  Function code. 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO. Any other code is ignored.
- `operand_a`  in  32  rs value: dividend, multiplicand, or MTHI/MTLO source.
- `operand_b`  in  32  rt value: divisor or multiplier.
- `flush`  in  1  Cancels the EX instruction and any divide in flight.
- `hi`  out  32  Architectural HI register.
- `lo`  out  32  Architectural LO register.
- `hilo_rdata`  out  32  Read data. Equals `hi` when funct is MFHI, `lo` when funct is MFLO, otherwise 0. Combinational.
- `stall_req`  out  1  Hold IF/ID/EX. Combinational.

## Operation
- Reset: `hi`=0, `lo`=0, state IDLE, iteration counter=0, `stall_req`=0.
- Instructions are accepted only in IDLE with `en`=1 and `flush`=0.
- MULT: `{hi,lo}` ← signed 32×32 → 64 product, written at the end of the accept cycle. No stall.
- MULTU: same as MULT, unsigned.
- MTHI: `hi` ← `operand_a` at the end of the accept cycle. MTLO does the same for `lo`.
- MFHI/MFLO: read-only. No state change.
- DIV/DIVU with divisor ≠ 0 runs the state machine:
  - IDLE → BUSY on accept. Latch |dividend| and |divisor| (raw values for DIVU). Latch quotient-sign = a[31]^b[31] and remainder-sign = a[31] (both 0 for DIVU). Clear the 33-bit partial remainder and the counter.
  - BUSY: one restoring-division step per cycle. Shift in the next dividend bit MSB-first, trial-subtract the divisor, and set the quotient bit if the result is non-negative. The counter increments. Go to DONE after the iteration with counter = DIV_CYCLES−1.
  - DONE: apply the signs (two's-complement negate where the sign is set). Write `lo` ← quotient and `hi` ← remainder at the end of the cycle, then return to IDLE.
- DIV/DIVU with divisor = 0: no state change. `hi`/`lo` unchanged. No stall.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0 (natural wrap, no trap).
- Re-accept guard: the held DIV seen again in BUSY/DONE is never re-accepted. Acceptance happens in IDLE only.
- `flush`, any state: next state IDLE. No write of `hi`/`lo` that cycle, even for a MULT/MT*/DONE in the same cycle. `stall_req` is 0 in the flush cycle.
- Reset mid-divide: immediate IDLE. `hi`/`lo` cleared.

## Timing
- MULT/MULTU/MTHI/MTLO have latency 1. A dependent MFHI/MFLO in the next cycle reads the new value. No bypass is required.
- DIV/DIVU, with cycle 0 as the accept cycle:
  - `stall_req`=1 in cycles 0 through 32: the accept cycle plus the 32 BUSY cycles.
  - Cycle 33 is DONE with `stall_req`=0. `hi`/`lo` are valid from cycle 34.
  - Total occupancy is 34 cycles.
- `stall_req` = (IDLE & en & ~flush & funct∈{DIV,DIVU} & operand_b≠0) | BUSY, gated by ~flush.
- Operands latched at accept. Changes to `operand_a`/`operand_b` during BUSY are ignored.

## Test plan
- After reset, MFHI and MFLO each give `hilo_rdata`=0. MTHI 0x12345678 then MFHI on the next cycle gives 0x12345678.
- MULT 0xFFFFFFFF × 0x00000002 gives `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE. MULTU on the same operands gives `hi`=0x00000001, `lo`=0xFFFFFFFE. No stall.
- DIV −7 / 2 gives `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. `stall_req` is high for exactly 33 cycles and the result is visible in cycle 34. DIVU 100/7 gives `lo`=14, `hi`=2.
- DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. DIV 5/0 gives no stall and `hi`/`lo` unchanged.
- Assert `flush` in cycle 10 of a DIV: `stall_req` drops that cycle, `hi`/`lo` are unchanged, and a following MULTU is accepted the next cycle.
- Assert `rst` low asynchronously at cycle 20 of a DIV: `hi`=`lo`=0 and `stall_req`=0 immediately. After release, a new DIVU 9/3 gives `lo`=3, `hi`=0.
